jk_mod_counter: RTL and testbench

- Synchronous modulo-N up/down counter built as a bank of clocked JK cells.
- Per-bit next-state logic computes J/K commands: hold, set, clear or toggle.
- Sits directly upstream of the JK storage stage and drives it.
- Provides the team's standard divide-by-N / event-count primitive; terminal-count pulse is used to cascade stages.

---
 rtl/jk_pkg.sv | 23 ++
 rtl/jk_mod_counter_if.sv | 22 ++
 rtl/jk_mod_counter_cell.sv | 34 +++
 rtl/jk_mod_counter.sv | 88 ++++++++
 tb/tb_jk_mod_counter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared JK command encoding and its mapping onto the J/K input pair.
package jk_pkg;

  typedef enum logic [1:0] {
    JK_HOLD,
    JK_CLEAR,
    JK_SET,
    JK_TOGGLE
  } jk_cmd_t;

  function automatic logic [1:0] jk_cmd_to_jk(input jk_cmd_t cmd);
    logic [1:0] jk;
    case (cmd)
      JK_HOLD:   jk = 2'b00;
      JK_CLEAR:  jk = 2'b01;
      JK_SET:    jk = 2'b10;
      JK_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_mod_counter_if.sv
// Control and status bundle for the modulo-N JK counter.
interface jk_mod_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;

  modport master (
    output en, up, load, load_val,
    input  q, qbar, tc
  );

  modport slave (
    input  en, up, load, load_val,
    output q, qbar, tc
  );
endinterface

// File: rtl/jk_mod_counter_cell.sv
// Single clocked JK storage element with synchronous active-high reset.
module jk_cell (
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= 1'b0;
      qbar <= 1'b1;
    end else begin
      case ({j, k})
        2'b01: begin
          q    <= 1'b0;
          qbar <= 1'b1;
        end
        2'b10: begin
          q    <= 1'b1;
          qbar <= 1'b0;
        end
        2'b11: begin
          q    <= ~q;
          qbar <= q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter: next-value logic derives per-bit JK commands
// that drive a bank of jk_cell storage elements; tc pulses after each wrap.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  jk_mod_counter_if.slave  bus
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_cur;
  logic [WIDTH-1:0] qbar_cur;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH:0]   inc_ext;
  logic             wrap;
  logic             tc_r;

  // Increment is widened by one bit so MODULUS == 2^WIDTH still compares correctly.
  assign inc_ext = {1'b0, q_cur} + 1'b1;

  always_comb begin
    nxt  = q_cur;
    wrap = 1'b0;
    if (bus.load) begin
      nxt = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : MAX_VAL;
    end else if (bus.en) begin
      if (bus.up) begin
        if (inc_ext == MOD_EXT) begin
          nxt  = '0;
          wrap = 1'b1;
        end else begin
          nxt = inc_ext[WIDTH-1:0];
        end
      end else begin
        if (q_cur == '0) begin
          nxt  = MAX_VAL;
          wrap = 1'b1;
        end else begin
          nxt = q_cur - 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cmd_t cmd;
    logic    j;
    logic    k;

    // Falling bits always use TOGGLE rather than CLEAR.
    always_comb begin
      cmd = JK_HOLD;
      if (reset)
        cmd = JK_CLEAR;
      else if (q_cur[i] != nxt[i])
        cmd = nxt[i] ? JK_SET : JK_TOGGLE;
    end

    assign {j, k} = jk_cmd_to_jk(cmd);

    jk_cell u_cell (
      .clk  (clk),
      .reset(reset),
      .j    (j),
      .k    (k),
      .q    (q_cur[i]),
      .qbar (qbar_cur[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)
      tc_r <= 1'b0;
    else
      tc_r <= wrap;
  end

  assign bus.q    = q_cur;
  assign bus.qbar = qbar_cur;
  assign bus.tc   = tc_r;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed bench for jk_mod_counter: mod-10 (WIDTH=4) and mod-8 (WIDTH=3) instances.
module tb_jk_mod_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;
  int   ntests = 0;
  int   nfail  = 0;

  always #5 clk = ~clk;

  jk_mod_counter_if #(.WIDTH(4)) bus ();
  jk_mod_counter_if #(.WIDTH(3)) bus8 ();

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  jk_mod_counter #(.WIDTH(3), .MODULUS(8)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus8)
  );

  // qbar must be the complement of q on every cycle after reset.
  always @(negedge clk) begin
    if (chk_en) begin
      ntests++;
      if (bus.qbar !== ~bus.q) begin
        nfail++;
        $display("FAIL qbar_inv: qbar=%h q=%h", bus.qbar, bus.q);
      end
      ntests++;
      if (bus8.qbar !== ~bus8.q) begin
        nfail++;
        $display("FAIL qbar_inv8: qbar=%h q=%h", bus8.qbar, bus8.q);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    ntests++;
    if (bus.q !== 4'h0) begin nfail++; $display("FAIL reset_q: got %h exp 0", bus.q); end
    ntests++;
    if (bus.qbar !== 4'hF) begin nfail++; $display("FAIL reset_qbar: got %h exp F", bus.qbar); end
    ntests++;
    if (bus.tc !== 1'b0) begin nfail++; $display("FAIL reset_tc: got %b exp 0", bus.tc); end
    ntests++;
    if (bus8.q !== 3'h0) begin nfail++; $display("FAIL reset_q8: got %h exp 0", bus8.q); end
    reset  = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] exp_q;
    bus.en = 1'b1;
    bus.up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      exp_q = 4'(i % 10);
      ntests++;
      if (bus.q !== exp_q) begin nfail++; $display("FAIL up_q[%0d]: got %0d exp %0d", i, bus.q, exp_q); end
      ntests++;
      if (bus.tc !== (i == 10)) begin nfail++; $display("FAIL up_tc[%0d]: got %b exp %b", i, bus.tc, (i == 10)); end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_count_down();
    logic [3:0] exp_q [3] = '{4'd9, 4'd8, 4'd7};
    logic       exp_tc [3] = '{1'b1, 1'b0, 1'b0};
    bus.load = 1'b1;
    bus.load_val = 4'd0;
    step();
    bus.load = 1'b0;
    ntests++;
    if (bus.q !== 4'd0) begin nfail++; $display("FAIL down_load0: got %0d exp 0", bus.q); end
    bus.en = 1'b1;
    bus.up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      ntests++;
      if (bus.q !== exp_q[i]) begin nfail++; $display("FAIL down_q[%0d]: got %0d exp %0d", i, bus.q, exp_q[i]); end
      ntests++;
      if (bus.tc !== exp_tc[i]) begin nfail++; $display("FAIL down_tc[%0d]: got %b exp %b", i, bus.tc, exp_tc[i]); end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_load_clamp();
    bus.load = 1'b1;
    bus.load_val = 4'd13;
    step();
    bus.load = 1'b0;
    ntests++;
    if (bus.q !== 4'd9) begin nfail++; $display("FAIL clamp_q: got %0d exp 9", bus.q); end
    ntests++;
    if (bus.tc !== 1'b0) begin nfail++; $display("FAIL clamp_tc: got %b exp 0", bus.tc); end
    bus.en = 1'b1;
    bus.up = 1'b1;
    step();
    bus.en = 1'b0;
    ntests++;
    if (bus.q !== 4'd0) begin nfail++; $display("FAIL clamp_wrap_q: got %0d exp 0", bus.q); end
    ntests++;
    if (bus.tc !== 1'b1) begin nfail++; $display("FAIL clamp_wrap_tc: got %b exp 1", bus.tc); end
    step();
    ntests++;
    if (bus.tc !== 1'b0) begin nfail++; $display("FAIL clamp_tc_drop: got %b exp 0", bus.tc); end
    ntests++;
    if (bus.q !== 4'd0) begin nfail++; $display("FAIL hold_q: got %0d exp 0", bus.q); end
  endtask

  task automatic test_load_vs_en();
    bus.load = 1'b1;
    bus.load_val = 4'd9;
    step();
    bus.load_val = 4'd3;
    bus.en = 1'b1;
    bus.up = 1'b1;
    step();
    bus.load = 1'b0;
    bus.en = 1'b0;
    ntests++;
    if (bus.q !== 4'd3) begin nfail++; $display("FAIL load_en_q: got %0d exp 3", bus.q); end
    ntests++;
    if (bus.tc !== 1'b0) begin nfail++; $display("FAIL load_en_tc: got %b exp 0", bus.tc); end
  endtask

  task automatic test_reset_mid();
    bus.load = 1'b1;
    bus.load_val = 4'd4;
    step();
    bus.load = 1'b0;
    bus.en = 1'b1;
    bus.up = 1'b1;
    step();
    ntests++;
    if (bus.q !== 4'd5) begin nfail++; $display("FAIL mid_pre_q: got %0d exp 5", bus.q); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    ntests++;
    if (bus.q !== 4'd0) begin nfail++; $display("FAIL mid_q: got %0d exp 0", bus.q); end
    ntests++;
    if (bus.qbar !== 4'hF) begin nfail++; $display("FAIL mid_qbar: got %h exp F", bus.qbar); end
    ntests++;
    if (bus.tc !== 1'b0) begin nfail++; $display("FAIL mid_tc: got %b exp 0", bus.tc); end
    step();
    ntests++;
    if (bus.q !== 4'd1) begin nfail++; $display("FAIL mid_resume: got %0d exp 1", bus.q); end
    // Reset on the same edge as a pending wrap suppresses tc.
    bus.en = 1'b0;
    bus.load = 1'b1;
    bus.load_val = 4'd9;
    step();
    bus.load = 1'b0;
    bus.en = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.en = 1'b0;
    ntests++;
    if (bus.tc !== 1'b0) begin nfail++; $display("FAIL wrap_reset_tc: got %b exp 0", bus.tc); end
    ntests++;
    if (bus.q !== 4'd0) begin nfail++; $display("FAIL wrap_reset_q: got %0d exp 0", bus.q); end
  endtask

  task automatic test_direction_change();
    logic       dir [4]   = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] exp_q [4] = '{4'd1, 4'd2, 4'd1, 4'd2};
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up = dir[i];
      step();
      ntests++;
      if (bus.q !== exp_q[i]) begin nfail++; $display("FAIL dir_q[%0d]: got %0d exp %0d", i, bus.q, exp_q[i]); end
    end
    bus.en = 1'b0;
  endtask

  task automatic test_width3();
    logic [2:0] exp_q;
    bus8.en = 1'b1;
    bus8.up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (bus8.q == 3'd3) begin
        ntests++;
        if ({dut8.g_bit[2].u_cell.j, dut8.g_bit[2].u_cell.k} !== 2'b10) begin
          nfail++;
          $display("FAIL w3_set_jk: got %b exp 10", {dut8.g_bit[2].u_cell.j, dut8.g_bit[2].u_cell.k});
        end
      end
      if (bus8.q == 3'd7) begin
        ntests++;
        if ({dut8.g_bit[2].u_cell.j, dut8.g_bit[2].u_cell.k} !== 2'b11) begin
          nfail++;
          $display("FAIL w3_toggle_jk: got %b exp 11", {dut8.g_bit[2].u_cell.j, dut8.g_bit[2].u_cell.k});
        end
      end
      step();
      exp_q = 3'(i % 8);
      ntests++;
      if (bus8.q !== exp_q) begin nfail++; $display("FAIL w3_q[%0d]: got %0d exp %0d", i, bus8.q, exp_q); end
      ntests++;
      if (bus8.tc !== (i == 8)) begin nfail++; $display("FAIL w3_tc[%0d]: got %b exp %b", i, bus8.tc, (i == 8)); end
    end
    bus8.en = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0;  bus.up = 1'b1;  bus.load = 1'b0;  bus.load_val = '0;
    bus8.en = 1'b0; bus8.up = 1'b1; bus8.load = 1'b0; bus8.load_val = '0;
    test_reset();
    test_count_up();
    test_count_down();
    test_load_clamp();
    test_load_vs_en();
    test_reset_mid();
    test_direction_change();
    test_width3();
    step();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
